// File: rtl/dlx_pkg.sv
// Shared DLX definitions: register-file geometry and the common address/word types.
package dlx_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREG   = 32;
    localparam int unsigned WIDTH  = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [WIDTH-1:0]  word_t;

    localparam reg_addr_t R0 = '0;

endpackage

// File: rtl/dlx_regfile_if.sv
// Decode/writeback side bundle of the DLX register file: read ports, writeback and issue.
interface dlx_regfile_if;
    import dlx_pkg::*;

    reg_addr_t         ra_addr;
    reg_addr_t         rb_addr;
    word_t             ra_data;
    word_t             rb_data;
    logic              wb_en;
    reg_addr_t         wb_addr;
    word_t             wb_data;
    logic              iss_valid;
    logic              iss_use_a;
    logic              iss_use_b;
    logic              iss_wr;
    reg_addr_t         iss_dest;
    logic              stall;
    logic [NREG-1:0]   busy;

    // Pipeline side: drives addresses, writeback and issue requests.
    modport master (
        output ra_addr, rb_addr, wb_en, wb_addr, wb_data,
        output iss_valid, iss_use_a, iss_use_b, iss_wr, iss_dest,
        input  ra_data, rb_data, stall, busy
    );

    // Register file side.
    modport slave (
        input  ra_addr, rb_addr, wb_en, wb_addr, wb_data,
        input  iss_valid, iss_use_a, iss_use_b, iss_wr, iss_dest,
        output ra_data, rb_data, stall, busy
    );

endinterface

// File: rtl/dlx_scoreboard.sv
// Pending-write scoreboard: one busy bit per register and the decode stall it implies.
module dlx_scoreboard
    import dlx_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  reg_addr_t       ra_addr,
    input  reg_addr_t       rb_addr,
    input  logic            wb_en,
    input  reg_addr_t       wb_addr,
    input  logic            iss_valid,
    input  logic            iss_use_a,
    input  logic            iss_use_b,
    input  logic            iss_wr,
    input  reg_addr_t       iss_dest,
    output logic            stall,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:1] busy_q, busy_d;
    logic            haz_a, haz_b, acc;

    // R0 never has an outstanding producer.
    assign busy = {busy_q, 1'b0};

    // A writeback landing this cycle resolves the hazard through the read bypass.
    always_comb begin
        haz_a = iss_use_a & busy[ra_addr] & ~(wb_en & (wb_addr == ra_addr));
        haz_b = iss_use_b & busy[rb_addr] & ~(wb_en & (wb_addr == rb_addr));
        stall = iss_valid & (haz_a | haz_b);
        acc   = iss_valid & ~stall;
    end

    // Set beats clear: a newly accepted producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (acc && iss_wr && (iss_dest == reg_addr_t'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wb_en && (wb_addr == reg_addr_t'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // Busy vector register, dropped entirely on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/mux32_1.sv
// One-bit 32:1 read-mux cell; one instance per data bit per read port.
module mux32_1 (
    input  logic [31:0] d,
    input  logic [4:0]  sel,
    output logic        y
);

    assign y = d[sel];

endmodule

// File: rtl/dlx_regfile.sv
// DLX architectural register file: 31 stored registers, R0 reads zero, two combinational
// read ports built from mux32_1 cells with write-first bypass, plus the issue scoreboard.
module dlx_regfile
    import dlx_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    dlx_regfile_if.slave  bus
);

    word_t             regs [1:NREG-1];
    logic [NREG-1:0]   col [WIDTH];
    word_t             mux_a, mux_b;

    // Register storage; writes to R0 are dropped since it has no flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_en) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (bus.wb_addr == reg_addr_t'(i)) begin
                    regs[i] <= bus.wb_data;
                end
            end
        end
    end

    // Transpose storage into per-bit mux inputs; input 0 is a dummy zero for R0.
    always_comb begin
        for (int unsigned b = 0; b < WIDTH; b++) begin
            col[b][0] = 1'b0;
            for (int unsigned i = 1; i < NREG; i++) begin
                col[b][i] = regs[i][b];
            end
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_rd_bit
        mux32_1 u_mux_a (
            .d   (col[b]),
            .sel (bus.ra_addr),
            .y   (mux_a[b])
        );
        mux32_1 u_mux_b (
            .d   (col[b]),
            .sel (bus.rb_addr),
            .y   (mux_b[b])
        );
    end

    // Bypass and R0 override sit after the mux; R0 override has the final word.
    always_comb begin
        bus.ra_data = mux_a;
        if (bus.wb_en && (bus.wb_addr == bus.ra_addr)) begin
            bus.ra_data = bus.wb_data;
        end
        if (bus.ra_addr == R0) begin
            bus.ra_data = '0;
        end
        bus.rb_data = mux_b;
        if (bus.wb_en && (bus.wb_addr == bus.rb_addr)) begin
            bus.rb_data = bus.wb_data;
        end
        if (bus.rb_addr == R0) begin
            bus.rb_data = '0;
        end
    end

    dlx_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra_addr   (bus.ra_addr),
        .rb_addr   (bus.rb_addr),
        .wb_en     (bus.wb_en),
        .wb_addr   (bus.wb_addr),
        .iss_valid (bus.iss_valid),
        .iss_use_a (bus.iss_use_a),
        .iss_use_b (bus.iss_use_b),
        .iss_wr    (bus.iss_wr),
        .iss_dest  (bus.iss_dest),
        .stall     (bus.stall),
        .busy      (bus.busy)
    );

endmodule

// File: tb/tb_dlx_regfile.sv
// Self-checking bench for dlx_regfile: hand vectors, reset corner cases and random traffic
// compared against an array-based reference model.
module tb_dlx_regfile;
    import dlx_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dlx_regfile_if bus ();

    dlx_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    typedef struct {
        logic        wb_en;
        reg_addr_t   wb_addr;
        word_t       wb_data;
        reg_addr_t   ra;
        reg_addr_t   rb;
        logic        iv;
        logic        ua;
        logic        ub;
        logic        iw;
        reg_addr_t   dest;
        word_t       exp_ra;
        word_t       exp_rb;
        logic        exp_stall;
        logic [31:0] exp_busy;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input reg_addr_t a);
        if (a == 5'd0) return 32'h0;
        if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_stall();
        logic ha, hb;
        ha = bus.iss_use_a && m_busy[bus.ra_addr] && !(bus.wb_en && bus.wb_addr == bus.ra_addr);
        hb = bus.iss_use_b && m_busy[bus.rb_addr] && !(bus.wb_en && bus.wb_addr == bus.rb_addr);
        return bus.iss_valid && (ha || hb);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_busy = 32'h0;
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic acc;
        if (!rst_n) return;
        acc = bus.iss_valid && !exp_stall();
        if (bus.wb_en && bus.wb_addr != 5'd0) begin
            m_regs[bus.wb_addr] = bus.wb_data;
            m_busy[bus.wb_addr] = 1'b0;
        end
        if (acc && bus.iss_wr && bus.iss_dest != 5'd0) m_busy[bus.iss_dest] = 1'b1;
    endtask

    task automatic model_comb_checks(input string tag);
        check({tag, "_ra"}, bus.ra_data, exp_read(bus.ra_addr));
        check({tag, "_rb"}, bus.rb_data, exp_read(bus.rb_addr));
        check({tag, "_stall"}, {31'b0, bus.stall}, {31'b0, exp_stall()});
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        model_comb_checks(tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_busy"}, bus.busy, m_busy);
    endtask

    task automatic idle();
        bus.ra_addr = '0; bus.rb_addr = '0;
        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.iss_valid = 1'b0; bus.iss_use_a = 1'b0; bus.iss_use_b = 1'b0;
        bus.iss_wr = 1'b0; bus.iss_dest = '0;
    endtask

    task automatic apply(input vec_t v);
        bus.wb_en = v.wb_en; bus.wb_addr = v.wb_addr; bus.wb_data = v.wb_data;
        bus.ra_addr = v.ra; bus.rb_addr = v.rb;
        bus.iss_valid = v.iv; bus.iss_use_a = v.ua; bus.iss_use_b = v.ub;
        bus.iss_wr = v.iw; bus.iss_dest = v.dest;
    endtask

    initial begin
        // wb_en addr data, ra rb, iv ua ub iw dest, exp_ra exp_rb stall busy-after
        vecs[0] = '{1'b1, 5'd5, 32'h12345678, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                    32'h12345678, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                    32'h12345678, 32'h0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0,
                    32'h0, 32'h0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7,
                    32'h12345678, 32'h12345678, 1'b0, 32'h0000_0080};
        vecs[4] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,
                    32'h12345678, 32'h0, 1'b1, 32'h0000_0080};
        vecs[5] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,
                    32'h12345678, 32'hA5A5A5A5, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 5'd9, 32'h00000099, 5'd9, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9,
                    32'h00000099, 32'hA5A5A5A5, 1'b0, 32'h0000_0200};
        vecs[7] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,
                    32'h00000099, 32'h0, 1'b1, 32'h0000_0200};

        idle();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Every address reads zero after reset, scoreboard empty.
        for (int i = 1; i < 32; i++) begin
            bus.ra_addr = reg_addr_t'(i);
            bus.rb_addr = reg_addr_t'(31 - i);
            #1;
            check("reset_ra", bus.ra_data, 32'h0);
            check("reset_rb", bus.rb_data, 32'h0);
        end
        check("reset_busy", bus.busy, 32'h0);
        idle();

        // Directed vectors: R5 write/bypass, R0 immutability, load-use stall, collision.
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            check("vec_ra", bus.ra_data, vecs[i].exp_ra);
            check("vec_rb", bus.rb_data, vecs[i].exp_rb);
            check("vec_stall", {31'b0, bus.stall}, {31'b0, vecs[i].exp_stall});
            model_comb_checks("vec_model");
            @(posedge clk);
            model_edge();
            #1;
            check("vec_busy", bus.busy, vecs[i].exp_busy);
            check("vec_model_busy", bus.busy, m_busy);
        end
        idle();
        bus.ra_addr = 5'd6;
        #1;
        check("r6_untouched", bus.ra_data, 32'h0);

        // Async reset between edges: R3 and busy[3] drop without a clock edge.
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h55;
        bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_dest = 5'd3;
        cycle("rst_setup");
        idle();
        bus.ra_addr = 5'd3;
        #1;
        check("pre_rst_r3", bus.ra_data, 32'h55);
        check("pre_rst_busy", bus.busy, 32'h0000_0208);
        rst_n = 1'b0;
        #1;
        check("async_rst_r3", bus.ra_data, 32'h0);
        check("async_rst_busy", bus.busy, 32'h0);
        model_reset();
        bus.iss_valid = 1'b1; bus.iss_use_a = 1'b1;
        #1;
        check("rst_stall", {31'b0, bus.stall}, 32'h0);
        idle();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'hCAFE;
        @(posedge clk);
        #1;
        bus.wb_en = 1'b0; bus.ra_addr = 5'd4;
        #1;
        check("write_in_reset", bus.ra_data, 32'h0);
        rst_n = 1'b1;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h77;
        cycle("post_rst_wr");
        idle();
        bus.ra_addr = 5'd3;
        #1;
        check("post_rst_r3", bus.ra_data, 32'h77);

        // Random traffic on a narrow address range to provoke hazards and collisions.
        for (int n = 0; n < 400; n++) begin
            bus.ra_addr   = reg_addr_t'($urandom_range(0, 7));
            bus.rb_addr   = reg_addr_t'($urandom_range(0, 7));
            bus.wb_en     = ($urandom_range(0, 2) == 0);
            bus.wb_addr   = reg_addr_t'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            bus.iss_valid = ($urandom_range(0, 3) != 0);
            bus.iss_use_a = $urandom_range(0, 1) == 1;
            bus.iss_use_b = $urandom_range(0, 1) == 1;
            bus.iss_wr    = $urandom_range(0, 1) == 1;
            bus.iss_dest  = reg_addr_t'($urandom_range(0, 7));
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
